// File: rtl/oled_fill_window_if.sv
// rtl/oled_fill_window_if.sv - byte request/acknowledge link between an OLED engine and the shared SPI byte sender
`timescale 1ns/1ps

interface oled_fill_window_if;
    logic       spi_send;
    logic [7:0] spi_data;
    logic       dc;
    logic       send_done;

    modport master (
        output spi_send,
        output spi_data,
        output dc,
        input  send_done
    );

    modport slave (
        input  spi_send,
        input  spi_data,
        input  dc,
        output send_done
    );
endinterface

// File: rtl/oled_fill_window.sv
// rtl/oled_fill_window.sv - fills a column/page window of OLED GDDRAM with one byte; OLED_FILL_AUTOINC_EN selects per-row addressing
`timescale 1ns/1ps

module oled_fill_window #(
    parameter int COLS   = 128,
    parameter int PAGES  = 8,
    parameter int COL_W  = 7,
    parameter int PAGE_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fill_start,
    input  logic [7:0]        fill_byte,
    input  logic [COL_W-1:0]  x0,
    input  logic [COL_W-1:0]  x1,
    input  logic [PAGE_W-1:0] p0,
    input  logic [PAGE_W-1:0] p1,
    oled_fill_window_if.master spi,
    output logic              busy,
    output logic              fill_done,
    output logic              fill_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LATCH,
        S_PAGE,
        S_COLH,
        S_COLL,
        S_DATA,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    // One extra bit so a bound equal to 2^COL_W / 2^PAGE_W still compares correctly.
    localparam logic [COL_W:0]  COL_LIM  = (COL_W + 1)'(COLS);
    localparam logic [PAGE_W:0] PAGE_LIM = (PAGE_W + 1)'(PAGES);

    state_t              state;
    state_t              state_nx;
    logic [COL_W-1:0]    col;
    logic [COL_W-1:0]    x0_q;
    logic [COL_W-1:0]    x1_q;
    logic [PAGE_W-1:0]   page;
    logic [PAGE_W-1:0]   p1_q;
    logic [7:0]          byte_q;
    logic                window_bad;
    logic                col_last;
    logic                page_last;
    logic [7:0]          col_ext;
    logic [3:0]          page_ext;

    assign window_bad = (x0 > x1) || (p0 > p1) ||
                        ({1'b0, x1} >= COL_LIM) || ({1'b0, p1} >= PAGE_LIM);
    assign col_last   = (col == x1_q);
    assign page_last  = (page == p1_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (fill_start) state_nx = S_LATCH;
            S_LATCH: state_nx = window_bad ? S_ERR : S_PAGE;
            S_PAGE:  if (spi.send_done) state_nx = S_COLH;
            S_COLH:  if (spi.send_done) state_nx = S_COLL;
            S_COLL:  if (spi.send_done) state_nx = S_DATA;
            S_DATA:  if (spi.send_done) state_nx = S_NEXT;
            S_NEXT: begin
                if (col_last && page_last) begin
                    state_nx = S_DONE;
                end else if (col_last) begin
                    state_nx = S_PAGE;
                end else begin
`ifdef OLED_FILL_AUTOINC_EN
                    // Panel advances its column pointer itself within a row.
                    state_nx = S_DATA;
`else
                    state_nx = S_PAGE;
`endif
                end
            end
            S_DONE:  state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col    <= '0;
            page   <= '0;
            x0_q   <= '0;
            x1_q   <= '0;
            p1_q   <= '0;
            byte_q <= 8'h00;
        end else begin
            case (state)
                S_LATCH: begin
                    byte_q <= fill_byte;
                    x0_q   <= x0;
                    x1_q   <= x1;
                    p1_q   <= p1;
                    col    <= x0;
                    page   <= p0;
                end
                S_NEXT: begin
                    if (!col_last) begin
                        col <= col + COL_W'(1);
                    end else if (!page_last) begin
                        col  <= x0_q;
                        page <= page + PAGE_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign col_ext  = 8'(col);
    assign page_ext = 4'(page);

    always_comb begin
        spi.spi_send = 1'b0;
        spi.spi_data = 8'h00;
        spi.dc       = 1'b0;
        case (state)
            S_PAGE: begin
                spi.spi_send = 1'b1;
                spi.spi_data = 8'hB0 | {4'h0, page_ext};
            end
            S_COLH: begin
                spi.spi_send = 1'b1;
                spi.spi_data = 8'h10 | {4'h0, col_ext[7:4]};
            end
            S_COLL: begin
                spi.spi_send = 1'b1;
                spi.spi_data = {4'h0, col_ext[3:0]};
            end
            S_DATA: begin
                spi.spi_send = 1'b1;
                spi.spi_data = byte_q;
                spi.dc       = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign fill_done = (state == S_DONE) || (state == S_ERR);
    assign fill_err  = (state == S_ERR);

endmodule
